// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the pipeline hazard controller.
//   hz_state_t : hazard FSM state (RUN, DWAIT, BUBBLE, HALTED)
//   regbits_t  : architectural register index (5 bits)
//   load_use() : detects a load in EX whose destination feeds the ID sources
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      BUBBLE = 2'd2,
      HALTED = 2'd3
   } hz_state_t;

   // $0 is hard-wired to zero, so a load targeting it can never create a
   // real dependency.
   function automatic logic load_use(input logic     ex_dren,
                                     input regbits_t ex_rd,
                                     input regbits_t id_rs,
                                     input regbits_t id_rt);
      return ex_dren && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
   endfunction

endpackage

// File: rtl/hz_perf_counter.sv
// Saturating event counter for pipeline stall statistics.
// Ports:
//   CLK   : clock, rising-edge
//   nRST  : synchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current count, sticks at all-ones
module hz_perf_counter #(
   parameter int CNTW = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            inc,
   output logic [CNTW-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNTW'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces per-latch write enables and flushes
// for data-memory stalls, load-use bubbles, taken control transfers,
// instruction-fetch misses and HALT.
// Ports:
//   CLK, nRST          : clock; synchronous active-low reset
//   ihit, dhit         : instruction / data memory completion
//   mem_dREN, mem_dWEN : MEM-stage load / store request
//   ex_dREN, ex_rd     : EX-stage load flag and destination register
//   id_rs, id_rt       : ID-stage source registers
//   jmp_taken          : jump or taken branch resolved this cycle
//   mem_halt           : HALT has reached MEM
//   wen, flush         : per-latch write enable / synchronous clear (comb.)
//   halted, hz_state   : registered halt flag and FSM state
//   stall_cnt          : saturating count of front-end stall cycles
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int NLATCH     = 4,
   parameter int BR_LATCH   = 2,
   parameter int LU_BUBBLES = 1,
   parameter int CNTW       = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              mem_dREN,
   input  logic              mem_dWEN,
   input  logic              ex_dREN,
   input  regbits_t          ex_rd,
   input  regbits_t          id_rs,
   input  regbits_t          id_rt,
   input  logic              jmp_taken,
   input  logic              mem_halt,
   output logic [NLATCH-1:0] wen,
   output logic [NLATCH-1:0] flush,
   output logic              halted,
   output hz_state_t         hz_state,
   output logic [CNTW-1:0]   stall_cnt
);

   localparam int             BCW       = 2;
   localparam logic [BCW-1:0] LU_RELOAD = BCW'(LU_BUBBLES - 1);

   // Load-use: hold IF/ID, clear ID/EX, let everything downstream advance.
   localparam logic [NLATCH-1:0] LU_WEN   = {{(NLATCH-1){1'b1}}, 1'b0};
   localparam logic [NLATCH-1:0] LU_FLUSH = NLATCH'(2);
   // Fetch miss: clear IF/ID, rest advances.
   localparam logic [NLATCH-1:0] IM_FLUSH = NLATCH'(1);
   // HALT: only MEM/WB is written so the HALT retires.
   localparam logic [NLATCH-1:0] HALT_WEN = {1'b1, {(NLATCH-1){1'b0}}};

   hz_state_t         state, next_state;
   logic [BCW-1:0]    bcnt, next_bcnt;
   logic [NLATCH-1:0] br_mask;
   logic              dstall;
   logic              lu_hit;
   logic              take_run;

   assign dstall = (mem_dREN || mem_dWEN) && !dhit;
   assign lu_hit = load_use(ex_dREN, ex_rd, id_rs, id_rt);

   always_comb begin
      br_mask = '0;
      for (int i = 0; i < NLATCH; i++) begin
         if (i < BR_LATCH) br_mask[i] = 1'b1;
      end
   end

   // NOTE: every output of this block is assigned a default first so no
   // path through the case statements can infer a latch.
   always_comb begin
      wen        = '0;
      flush      = '0;
      next_state = state;
      next_bcnt  = bcnt;
      take_run   = 1'b0;

      case (state)
         RUN, DWAIT: begin
            if (dstall) next_state = DWAIT;
            else        take_run   = 1'b1;
         end
         BUBBLE: begin
            // A data stall freezes the bubble sequence in place; HALT and
            // control transfers pre-empt the remaining bubbles.
            if (!dstall) begin
               if (mem_halt || jmp_taken) begin
                  take_run = 1'b1;
               end else begin
                  wen       = LU_WEN;
                  flush     = LU_FLUSH;
                  next_bcnt = bcnt - BCW'(1);
                  if (next_bcnt == '0) next_state = RUN;
               end
            end
         end
         HALTED: begin
         end
         default: next_state = RUN;
      endcase

      if (take_run) begin
         next_state = RUN;
         if (mem_halt) begin
            wen        = HALT_WEN;
            next_bcnt  = '0;
            next_state = HALTED;
         end else if (jmp_taken) begin
            wen       = '1;
            flush     = br_mask;
            next_bcnt = '0;
         end else if (lu_hit) begin
            wen   = LU_WEN;
            flush = LU_FLUSH;
            if (LU_BUBBLES > 1) begin
               next_bcnt  = LU_RELOAD;
               next_state = BUBBLE;
            end
         end else if (!ihit) begin
            wen   = LU_WEN;
            flush = IM_FLUSH;
         end else begin
            wen = '1;
         end
      end

      // Reset clears every latch combinationally, whatever the FSM is doing.
      if (!nRST) begin
         wen   = '0;
         flush = '1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= RUN;
         bcnt  <= '0;
      end else begin
         state <= next_state;
         bcnt  <= next_bcnt;
      end
   end

   assign hz_state = state;
   assign halted   = (state == HALTED);

   hz_perf_counter #(
      .CNTW (CNTW)
   ) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   ((!wen[0] || flush[0]) && (state != HALTED)),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl;
   import cpu_types_pkg::*;

   localparam int NL  = 4;
   localparam int BRL = 2;
   localparam int LUB = 2;
   localparam int CW  = 4;

   logic          CLK = 1'b0;
   logic          nRST, ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, jmp_taken, mem_halt;
   regbits_t      ex_rd, id_rs, id_rt;
   logic [NL-1:0] wen, flush;
   logic          halted;
   hz_state_t     hz_state;
   logic [CW-1:0] stall_cnt;

   always #5 CLK = ~CLK;

   hazard_ctrl #(.NLATCH(NL), .BR_LATCH(BRL), .LU_BUBBLES(LUB), .CNTW(CW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs(id_rs),
      .id_rt(id_rt), .jmp_taken(jmp_taken), .mem_halt(mem_halt), .wen(wen),
      .flush(flush), .halted(halted), .hz_state(hz_state), .stall_cnt(stall_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: halted flag, waiting on data memory, bubbles
   // still owed, and the stall count.
   bit m_halt, m_wait;
   int m_bub, m_cnt;

   logic [NL-1:0] obs_wen, obs_flush;
   hz_state_t     obs_state;
   logic          obs_halted;
   logic [CW-1:0] obs_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      nRST = 1; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_dREN = 0;
      ex_rd = 0; id_rs = 0; id_rt = 0; jmp_taken = 0; mem_halt = 0;
   endtask

   // One clock cycle: compare all outputs against the model, then advance.
   task automatic step(input string tag);
      logic [NL-1:0] ew, ef;
      hz_state_t     es;
      bit            dst, lu, n_halt, n_wait;
      int            n_bub, n_cnt;
      #1;
      obs_wen = wen; obs_flush = flush; obs_state = hz_state;
      obs_halted = halted; obs_cnt = stall_cnt;

      dst = (mem_dREN || mem_dWEN) && !dhit;
      lu  = ex_dREN && (ex_rd != 0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
      es  = m_halt ? HALTED : m_wait ? DWAIT : (m_bub > 0) ? BUBBLE : RUN;
      ew = '0; ef = '0; n_halt = m_halt; n_wait = m_wait; n_bub = m_bub;
      if (!nRST) begin
         ef = '1; n_halt = 0; n_wait = 0; n_bub = 0;
      end else if (m_halt) begin
      end else if (dst) begin
         if (m_bub == 0) n_wait = 1;
      end else begin
         n_wait = 0;
         if (mem_halt) begin
            ew = 4'b1000; n_halt = 1; n_bub = 0;
         end else if (jmp_taken) begin
            ew = '1; ef = NL'((1 << BRL) - 1); n_bub = 0;
         end else if (m_bub > 0) begin
            ew = 4'b1110; ef = 4'b0010; n_bub = m_bub - 1;
         end else if (lu) begin
            ew = 4'b1110; ef = 4'b0010; n_bub = LUB - 1;
         end else if (!ihit) begin
            ew = 4'b1110; ef = 4'b0001;
         end else begin
            ew = 4'b1111;
         end
      end
      if (!nRST) n_cnt = 0;
      else if (!m_halt && (!ew[0] || ef[0])) n_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else n_cnt = m_cnt;

      check({tag, ".wen"},    32'(wen),       32'(ew));
      check({tag, ".flush"},  32'(flush),     32'(ef));
      check({tag, ".state"},  32'(hz_state),  32'(es));
      check({tag, ".halted"}, 32'(halted),    32'(m_halt));
      check({tag, ".cnt"},    32'(stall_cnt), 32'(m_cnt));

      @(posedge CLK);
      m_halt = n_halt; m_wait = n_wait; m_bub = n_bub; m_cnt = n_cnt;
      @(negedge CLK);
   endtask

   initial begin
      idle();
      nRST = 0;
      m_halt = 0; m_wait = 0; m_bub = 0; m_cnt = 0;
      @(posedge CLK);
      @(negedge CLK);

      // Reset with noisy inputs: latches held clear.
      nRST = 0; ihit = 0; mem_dREN = 1; ex_dREN = 1; ex_rd = 3; id_rs = 3; jmp_taken = 1;
      step("rst");
      check("rst.wen0", 32'(obs_wen), 32'h0);
      check("rst.flushF", 32'(obs_flush), 32'hF);
      idle();

      step("run");
      check("run.wen", 32'(obs_wen), 32'hF);
      ihit = 0;
      step("imiss");
      check("imiss.flush", 32'(obs_flush), 32'h1);
      idle();

      // Load-use with two bubbles.
      nRST = 0; step("lu.rst"); idle(); step("lu.pre");
      ex_dREN = 1; ex_rd = 3; id_rs = 3; id_rt = 7;
      step("lu0");
      check("lu0.wen", 32'(obs_wen), 32'hE);
      check("lu0.flush", 32'(obs_flush), 32'h2);
      step("lu1");
      check("lu1.state", 32'(obs_state), 32'(BUBBLE));
      check("lu1.flush", 32'(obs_flush), 32'h2);
      idle();
      step("lu2");
      check("lu2.state", 32'(obs_state), 32'(RUN));
      check("lu2.cnt", 32'(obs_cnt), 32'd2);

      // $0 destination never stalls.
      ex_dREN = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
      step("rd0");
      check("rd0.wen", 32'(obs_wen), 32'hF);
      idle();

      // Data-memory stall for three cycles.
      mem_dREN = 1; dhit = 0;
      step("dw0");
      check("dw0.wen", 32'(obs_wen), 32'h0);
      step("dw1");
      check("dw1.state", 32'(obs_state), 32'(DWAIT));
      step("dw2");
      check("dw2.wen", 32'(obs_wen), 32'h0);
      dhit = 1;
      step("dw3");
      check("dw3.state", 32'(obs_state), 32'(DWAIT));
      check("dw3.wen", 32'(obs_wen), 32'hF);
      idle();

      // Jump overrides load-use.
      jmp_taken = 1; ex_dREN = 1; ex_rd = 5; id_rt = 5;
      step("jlu");
      check("jlu.flush", 32'(obs_flush), 32'h3);
      check("jlu.wen", 32'(obs_wen), 32'hF);
      idle();
      step("jlu.after");
      check("jlu.state", 32'(obs_state), 32'(RUN));

      // Halt, hold, then reset out of it.
      mem_halt = 1;
      step("halt");
      check("halt.wen", 32'(obs_wen), 32'h8);
      mem_halt = 0;
      for (int i = 0; i < 10; i++) begin
         ihit = 1'($urandom_range(0, 1)); jmp_taken = 1'($urandom_range(0, 1));
         step("halted");
         check("halted.flag", 32'(obs_halted), 32'd1);
         check("halted.wen", 32'(obs_wen), 32'h0);
      end
      idle(); nRST = 0;
      step("halt.rst");
      idle();
      step("halt.exit");
      check("halt.exit.state", 32'(obs_state), 32'(RUN));
      check("halt.exit.halted", 32'(obs_halted), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         nRST      = ($urandom_range(0, 40) != 0);
         ihit      = ($urandom_range(0, 3) != 0);
         dhit      = 1'($urandom_range(0, 1));
         mem_dREN  = ($urandom_range(0, 5) == 0);
         mem_dWEN  = ($urandom_range(0, 7) == 0);
         ex_dREN   = ($urandom_range(0, 2) == 0);
         ex_rd     = regbits_t'($urandom_range(0, 4));
         id_rs     = regbits_t'($urandom_range(0, 4));
         id_rt     = regbits_t'($urandom_range(0, 4));
         jmp_taken = ($urandom_range(0, 7) == 0);
         mem_halt  = ($urandom_range(0, 60) == 0);
         step("rand");
      end

      // Counter saturation.
      idle(); nRST = 0; step("sat.rst");
      idle(); ihit = 0;
      for (int i = 0; i < 20; i++) step("sat");
      check("sat.cnt", 32'(obs_cnt), 32'd15);
      step("sat.hold");
      check("sat.hold.cnt", 32'(obs_cnt), 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NLATCH, default 4, number of pipeline latches (0=IF/ID … NLATCH-1=MEM/WB), legal range 3..8.
REQ-002 SHALL have parameter BR_LATCH, default 2, index of first latch not flushed on a resolved branch/jump; latches 0..BR_LATCH-1 are flushed.
REQ-003 SHALL have parameter LU_BUBBLES, default 1, bubbles inserted per load-use hazard, legal range 1..3.
REQ-004 SHALL have parameter CNTW, default 32, stall-counter width.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 nRST  in  1  reset, synchronous, active-low.
REQ-007 ihit  in  1  instruction memory returned valid instruction this cycle.
REQ-008 dhit  in  1  data memory completed the MEM-stage request this cycle.
REQ-009 mem_dREN, mem_dWEN  in  1 each  MEM-stage load/store request.
REQ-010 ex_dREN  in  1  instruction in EX is a load.
REQ-011 ex_rd, id_rs, id_rt  in  regbits_t (5)  EX destination, ID sources.
REQ-012 jmp_taken  in  1  jump/JR/JAL or taken branch resolved this cycle.
REQ-013 mem_halt  in  1  HALT has reached MEM stage.
REQ-014 wen  out  NLATCH  per-latch write enable.
REQ-015 flush  out  NLATCH  per-latch synchronous clear (bubble insert).
REQ-016 halted  out  1  sticky halt indication.
REQ-017 hz_state  out  hz_state_t  current FSM state.
REQ-018 stall_cnt  out  CNTW  saturating count of cycles with wen[0]=0 or flush[0]=1.

Function
REQ-019 SHALL implement FSM states RUN, DWAIT, BUBBLE, HALTED.
REQ-020 RUN, no hazard: wen all 1 when ihit=1; when ihit=0, wen[0]=0, flush[0]=1, wen[NLATCH-1:1] all 1.
REQ-021 RUN, (mem_dREN|mem_dWEN) & !dhit: wen all 0, flush all 0 same cycle; next state DWAIT.
REQ-022 DWAIT: wen all 0 until dhit=1; on dhit cycle apply RUN rules (REQ-020/023/024) and next state RUN, or BUBBLE if load-use fires that cycle.
REQ-023 Load-use (ex_dREN & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)), not stalled by REQ-021: wen[0]=0, flush[1]=1, wen[NLATCH-1:2] all 1; if LU_BUBBLES>1, load counter with LU_BUBBLES-1, next state BUBBLE.
REQ-024 BUBBLE: repeat REQ-023 outputs each cycle, decrement counter; return to RUN the cycle counter reaches 0.
REQ-025 jmp_taken in RUN/BUBBLE, not stalled by REQ-021: flush[BR_LATCH-1:0] all 1, wen all 1, bubble counter cleared, next state RUN; jmp_taken overrides load-use.
REQ-026 mem_halt with no pending data stall: wen[NLATCH-1]=1, other wen 0; next state HALTED.
REQ-027 HALTED: wen all 0, flush all 0, halted=1; exits only on reset.
REQ-028 Priority when simultaneous: HALTED > data stall > mem_halt > jmp_taken > load-use > !ihit.
REQ-029 ex_rd==0 SHALL never trigger load-use.
REQ-030 stall_cnt SHALL increment per qualifying cycle, saturate at all-ones, not count in HALTED.
REQ-031 All outputs except stall_cnt, hz_state, halted SHALL be combinational from inputs and state; no cycle of added latency.

Reset
REQ-032 nRST=0 at a rising edge: state RUN, bubble counter 0, halted 0, stall_cnt 0.
REQ-033 While nRST=0: wen all 0, flush all 1, regardless of other inputs, including mid-DWAIT or mid-BUBBLE.

Structure
REQ-034 hz_state_t (enum RUN, DWAIT, BUBBLE, HALTED) and regbits_t SHALL live in cpu_types_pkg.
REQ-035 Saturating counter SHALL be sub-module hz_perf_counter (parameter CNTW, inputs CLK, nRST, inc).

Verification
REQ-036 Load lw $3 in EX, ID reads rs=$3, LU_BUBBLES=2 -> two cycles wen[0]=0, flush[1]=1, state RUN→BUBBLE→RUN, stall_cnt +2.
REQ-037 mem_dREN=1, dhit=0 for 3 cycles then 1 -> wen=0000 for 3 cycles, 1111 on dhit cycle, state DWAIT 3 cycles.
REQ-038 jmp_taken and load-use same cycle, BR_LATCH=2 -> flush=0011, wen=1111, next state RUN.
REQ-039 mem_halt=1 -> wen=1000 that cycle, then halted=1, wen=0000 held 10 cycles; nRST=0 -> state RUN, halted 0.
REQ-040 ex_rd=0, id_rs=0, ex_dREN=1 -> no stall, wen=1111.
REQ-041 CNTW=4, 20 ihit=0 cycles -> stall_cnt=15 held.
